uart_receiver: RTL

UART receive stage: the downstream partner of `transmitter`, consuming its `tx` line. It turns a serial frame (start bit, `WORD_SIZE` data bits LSB-first, stop bit) back into a parallel word. The serial input passes through a 2-flop synchronizer, and each bit is sampled at mid-bit using the same `PULSE_WIDTH` clocks-per-bit timing as the transmitter. Received words are presented on a valid/ready handshake to the consumer (FIFO or host logic), with frame-error and overrun reporting.

---
 rtl/uart_pkg.sv | 10 +
 rtl/bit_sync.sv | 27 ++
 rtl/uart_receiver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and receiver FSM states.
package uart_pkg;

    localparam int DEFAULT_WORD_SIZE   = 8;
    localparam int DEFAULT_PULSE_WIDTH = 4;
    localparam int DEFAULT_PACKET_SIZE = DEFAULT_WORD_SIZE + 2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_q;
    logic ff2_q;

    // Shift the async input through two flops before anyone looks at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_q <= RESET_VAL;
            ff2_q <= RESET_VAL;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: synchronizes rx, samples each bit at mid-bit and presents
// complete words on a valid/ready handshake with frame-error and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int PULSE_WIDTH = DEFAULT_PULSE_WIDTH,
    parameter int PACKET_SIZE = DEFAULT_PACKET_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [WORD_SIZE-1:0] data_bits,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int H  = PULSE_WIDTH / 2;
    localparam int CW = $clog2(PULSE_WIDTH);
    localparam int IW = $clog2(WORD_SIZE + 1);

    localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(PULSE_WIDTH - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_SIZE - 1);

    if (PACKET_SIZE != WORD_SIZE + 2) begin : g_bad_packet_size
        $error("PACKET_SIZE must equal WORD_SIZE + 2");
    end
    if ((PULSE_WIDTH < 4) || (PULSE_WIDTH % 2 != 0)) begin : g_bad_pulse_width
        $error("PULSE_WIDTH must be even and at least 4");
    end

    rx_state_t state_q, state_d;

    logic                 rx_s;
    logic                 rx_prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [WORD_SIZE-1:0] shreg_q, shreg_d;
    logic [WORD_SIZE-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic fall_edge;
    logic start_chk;
    logic data_smp;
    logic stop_smp;
    logic load;

    bit_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Previous synchronized level, for falling-edge detection of the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: an edge (not a level) is needed to leave IDLE, so a held-low
    // line never re-triggers.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fall_edge) state_d = START;
            START:   if (start_chk) state_d = rx_s ? IDLE : DATA;
            DATA:    if (data_smp && (idx_q == IDX_LAST)) state_d = STOP;
            STOP:    if (stop_smp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: sampling strobes, word load decision and busy.
    always_comb begin
        fall_edge = rx_prev_q & ~rx_s;
        start_chk = (state_q == START) && (cnt_q == CNT_MID);
        data_smp  = (state_q == DATA) && (cnt_q == CNT_END);
        stop_smp  = (state_q == STOP) && (cnt_q == CNT_END);
        // A consumer accepting this cycle frees the slot for the new word.
        load      = stop_smp & rx_s & (~valid_q | rx_ready);
        busy      = (state_q != IDLE);
    end

    // Bit timing counter, bit index and LSB-first shift register.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START: begin
                cnt_d = start_chk ? '0 : cnt_q + CW'(1);
            end
            DATA: begin
                if (data_smp) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IW'(1);
                    shreg_d = {rx_s, shreg_q[WORD_SIZE-1:1]};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                cnt_d = stop_smp ? '0 : cnt_q + CW'(1);
            end
            default: begin
                cnt_d = '0;
                idx_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Output word register, handshake and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_smp & ~rx_s;
            overrun_q   <= stop_smp & rx_s & valid_q & ~rx_ready;
            if (load) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_bits = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
